// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : operation encoding and status constants for sync_arith_unit_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        ALU_SUB  = 2'b00,
        ALU_COMP = 2'b01,
        ALU_SUM  = 2'b10,
        ALU_CONV = 2'b11
    } alu_op_e;

    localparam logic [3:0] STATUS_OVF      = 4'b1001;
    localparam int         STATUS_EVEN_BIT = 2;
    localparam int         STATUS_ONES_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/sync_arith_core.sv
// ---------------------------------------------------------------------------
// sync_arith_core : combinational raw result and overflow for the four ops
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_arith_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_arg_a,
    input  logic [WIDTH-1:0] i_arg_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    localparam int               IDX_W  = $clog2(WIDTH);
    localparam logic [WIDTH-2:0] MAG_ONE = 1;

    logic [WIDTH+1:0] sub_full;
    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_clr;
    logic [WIDTH-2:0] mag;
    logic             sub_ovf;
    logic             sum_ovf;
    logic             conv_ovf;

    always_comb begin
        // Both operands extended to WIDTH+2 so A - 2B cannot wrap.
        sub_full = {{2{i_arg_a[WIDTH-1]}}, i_arg_a} - {i_arg_b[WIDTH-1], i_arg_b, 1'b0};
        sub_ovf  = !((&sub_full[WIDTH+1:WIDTH-1]) || !(|sub_full[WIDTH+1:WIDTH-1]));

        sum_full = {i_arg_a[WIDTH-1], i_arg_a} + {i_arg_b[WIDTH-1], i_arg_b};
        sum_ovf  = sum_full[WIDTH] ^ sum_full[WIDTH-1];
        sum_clr  = sum_full[WIDTH-1:0];
        if (i_arg_b[WIDTH-1:IDX_W] == '0) begin
            sum_clr[i_arg_b[IDX_W-1:0]] = 1'b0;
        end

        mag      = ~i_arg_a[WIDTH-2:0] + MAG_ONE;
        conv_ovf = i_arg_a[WIDTH-1] && (i_arg_a[WIDTH-2:0] == '0);

        o_result = '0;
        o_ovf    = 1'b0;
        case (alu_op_e'(i_op))
            ALU_SUB: begin
                o_ovf    = sub_ovf;
                o_result = sub_ovf ? '0 : sub_full[WIDTH-1:0];
            end
            ALU_COMP: begin
                o_result[0] = $signed(i_arg_a) < $signed(i_arg_b);
            end
            ALU_SUM: begin
                o_ovf    = sum_ovf;
                o_result = sum_ovf ? '0 : sum_clr;
            end
            ALU_CONV: begin
                o_ovf = conv_ovf;
                if (conv_ovf) begin
                    o_result = '0;
                end else if (i_arg_a[WIDTH-1]) begin
                    o_result = {1'b1, mag};
                end else begin
                    o_result = i_arg_a;
                end
            end
            default: begin
                o_result = '0;
                o_ovf    = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sync_arith_unit_pipe.sv
// ---------------------------------------------------------------------------
// sync_arith_unit_pipe : 2-stage valid/ready arithmetic unit with overflow count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_arith_unit_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_arg_A,
    input  logic [WIDTH-1:0] i_arg_B,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_status,
    input  logic             i_clr_cnt,
    output logic [CNT_W-1:0] o_ovf_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] core_result;
    logic             core_ovf;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_result_q, s1_result_d;
    logic             s1_ovf_q, s1_ovf_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [3:0]       s2_status_q, s2_status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_adv;
    logic             s1_load;
    logic             s2_load;
    logic             ovf_done;
    logic [3:0]       flags;

    sync_arith_core #(.WIDTH(WIDTH)) u_core (
        .i_op     (i_op),
        .i_arg_a  (i_arg_A),
        .i_arg_b  (i_arg_B),
        .o_result (core_result),
        .o_ovf    (core_ovf)
    );

    always_comb begin
        s2_adv  = !s2_valid_q || i_ready;
        o_ready = !s1_valid_q || s2_adv;
        s1_load = i_valid && o_ready;
        s2_load = s2_adv && s1_valid_q;

        s1_valid_d  = o_ready ? i_valid : s1_valid_q;
        s1_result_d = s1_load ? core_result : s1_result_q;
        s1_ovf_d    = s1_load ? core_ovf : s1_ovf_q;

        flags = '0;
        if (s1_ovf_q) begin
            flags = STATUS_OVF;
        end else begin
            flags[STATUS_EVEN_BIT] = ~^s1_result_q;
            flags[STATUS_ONES_BIT] = &s1_result_q;
        end

        // Data registers only move when a real beat advances, so a stalled
        // output holds its value.
        s2_valid_d  = s2_adv ? s1_valid_q : s2_valid_q;
        s2_result_d = s2_load ? (s1_ovf_q ? '0 : s1_result_q) : s2_result_q;
        s2_status_d = s2_load ? flags : s2_status_q;

        ovf_done = s2_valid_q && i_ready && (s2_status_q == STATUS_OVF);
        cnt_d    = cnt_q;
        if (i_clr_cnt) begin
            cnt_d = '0;
        end else if (ovf_done && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            s1_valid_q  <= 1'b0;
            s1_result_q <= '0;
            s1_ovf_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_status_q <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_result_q <= s1_result_d;
            s1_ovf_q    <= s1_ovf_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_status_q <= s2_status_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_valid     = s2_valid_q;
    assign o_result    = s2_result_q;
    assign o_status    = s2_status_q;
    assign o_ovf_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_arith_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_sync_arith_unit_pipe : directed + random bench with an integer reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_arith_unit_pipe;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [1:0]       i_op = 2'b00;
    logic [WIDTH-1:0] i_arg_A = '0;
    logic [WIDTH-1:0] i_arg_B = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [WIDTH-1:0] o_result;
    logic [3:0]       o_status;
    logic             i_clr_cnt = 1'b0;
    logic [CNT_W-1:0] o_ovf_count;

    int n_total = 0;
    int n_bad   = 0;
    int m_cnt   = 0;
    logic [11:0] sb[$];

    sync_arith_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_arg_A     (i_arg_A),
        .i_arg_B     (i_arg_B),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_status    (o_status),
        .i_clr_cnt   (i_clr_cnt),
        .o_ovf_count (o_ovf_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {result[7:0], status[3:0]} from the arithmetic definition.
    function automatic logic [11:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa = $signed(a);
        int sbv = $signed(b);
        int r = 0;
        bit ovf = 0;
        logic [7:0] res;
        logic [3:0] st;
        case (op)
            2'd0: begin r = sa - 2 * sbv; ovf = (r < -128) || (r > 127); end
            2'd1: r = (sa < sbv) ? 1 : 0;
            2'd2: begin
                r = sa + sbv;
                ovf = (r < -128) || (r > 127);
                if (!ovf && b < 8) r = r & ~(1 << b);
            end
            default: begin
                if (sa == -128) ovf = 1;
                else if (sa < 0) r = 128 + (-sa);
                else r = sa;
            end
        endcase
        res = ovf ? 8'h00 : r[7:0];
        if (ovf) st = 4'b1001;
        else st = {1'b0, ($countones(res) % 2) == 0, res == 8'hFF, 1'b0};
        return {res, st};
    endfunction

    // One clock cycle: drive at negedge, check, update scoreboard for the coming edge.
    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic rdy, input logic clr, output bit acc);
        bit comp;
        @(negedge i_clk);
        i_valid = v; i_op = op; i_arg_A = a; i_arg_B = b; i_ready = rdy; i_clr_cnt = clr;
        #1;
        chk("ovf_count", 32'(o_ovf_count), 32'(m_cnt));
        if (o_valid) begin
            if (sb.size() == 0) chk("spurious_valid", 32'(o_valid), 32'd0);
            else chk("result_status", 32'({o_result, o_status}), 32'(sb[0]));
        end
        acc  = v && o_ready;
        comp = o_valid && rdy && (sb.size() != 0);
        if (comp) begin
            if (clr) m_cnt = 0;
            else if (sb[0][3:0] == 4'b1001 && m_cnt < CNT_MAX) m_cnt++;
            void'(sb.pop_front());
        end else if (clr) begin
            m_cnt = 0;
        end
        if (acc) sb.push_back(model(op, a, b));
    endtask

    task automatic idle(input logic rdy);
        bit acc;
        step(1'b0, 2'd0, 8'h00, 8'h00, rdy, 1'b0, acc);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1'b1);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic run_one(input string tag, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [11:0] exp);
        bit acc;
        step(1'b1, op, a, b, 1'b1, 1'b0, acc);
        chk({tag, "_accept"}, 32'(acc), 32'd1);
        idle(1'b1);
        chk({tag, "_early"}, 32'(o_valid), 32'd0);
        idle(1'b1);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk(tag, 32'({o_result, o_status}), 32'(exp));
    endtask

    initial begin
        logic [7:0] beats_a[4];
        bit acc;
        int idx;

        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_status", 32'(o_status), 32'd0);
        chk("rst_count", 32'(o_ovf_count), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);

        run_one("sub_basic", 2'd0, 8'h0A, 8'h03, {8'h04, 4'b0000});
        run_one("sub_ovf",   2'd0, 8'h9C, 8'h14, {8'h00, 4'b1001});
        idle(1'b1);
        chk("ovf_count_one", 32'(o_ovf_count), 32'd1);
        run_one("sum_clr",   2'd2, 8'h05, 8'h02, {8'h03, 4'b0100});
        run_one("sum_bigb",  2'd2, 8'h01, 8'h0A, {8'h0B, 4'b0000});
        run_one("conv_neg",  2'd3, 8'hFB, 8'h00, {8'h85, 4'b0000});
        run_one("conv_min",  2'd3, 8'h80, 8'h00, {8'h00, 4'b1001});
        run_one("conv_m1",   2'd3, 8'hFF, 8'h00, {8'h81, 4'b0100});
        run_one("comp_ge",   2'd1, 8'hFE, 8'hFD, {8'h00, 4'b0100});
        run_one("comp_lt",   2'd1, 8'hFD, 8'hFE, {8'h01, 4'b0000});
        run_one("comp_eq",   2'd1, 8'h7F, 8'h7F, {8'h00, 4'b0100});
        run_one("sub_ones",  2'd0, 8'h01, 8'h01, {8'hFF, 4'b0110});
        drain();

        // Backpressure: four back-to-back beats against a stalled sink.
        beats_a = '{8'h10, 8'h21, 8'h32, 8'h43};
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            step(1'b1, 2'd2, beats_a[idx], 8'h08, (c >= 6), 1'b0, acc);
            if (c >= 2 && c < 6) chk("bp_ready_low", 32'(o_ready), 32'd0);
            if (c == 5) chk("bp_accepted", 32'(idx), 32'd2);
            if (acc) idx++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd4);
        drain();

        // Asynchronous reset with two beats in flight.
        step(1'b1, 2'd0, 8'h9C, 8'h14, 1'b0, 1'b0, acc);
        step(1'b1, 2'd1, 8'h01, 8'h02, 1'b0, 1'b0, acc);
        idle(1'b0);
        chk("pre_rst_count", 32'(o_ovf_count != 0), 32'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_result", 32'(o_result), 32'd0);
        chk("arst_status", 32'(o_status), 32'd0);
        chk("arst_count", 32'(o_ovf_count), 32'd0);
        sb.delete();
        m_cnt = 0;
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("arst_ready", 32'(o_ready), 32'd1);
        run_one("post_rst", 2'd0, 8'h0A, 8'h03, {8'h04, 4'b0000});
        drain();

        // Clear coincides with an overflow beat completing.
        step(1'b1, 2'd0, 8'h9C, 8'h14, 1'b0, 1'b0, acc);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        idle(1'b1);
        chk("clr_wins", 32'(o_ovf_count), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom % 8)
                0: a = 8'h80;
                1: a = 8'h7F;
                2: b = 8'($urandom % 10);
                default: ;
            endcase
            step(($urandom % 4) != 0, 2'($urandom), a, b, ($urandom % 3) != 0,
                 ($urandom % 200) == 0, acc);
        end
        drain();
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_arith_unit_pipe.md
Name: sync_arith_unit_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit synchronous arithmetic unit.
- Same four operations (A−2B, signed A<B, (A+B) with bit B cleared, U2→ZM conversion) and the same 4-bit status encoding, at generic WIDTH.
- Adds a valid/ready handshake on both sides, a 2-stage pipeline with backpressure, and a saturating overflow-event counter.
- Sits between the operand sequencer and the result sink in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; minimum 4, power of two.
- CNT_W, 8, width of the overflow-event counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous reset, active low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  unit can accept an input beat.
- i_op  in  2  operation select: 00 SUB, 01 COMP, 10 SUM, 11 CONV.
- i_arg_A  in  WIDTH  operand A, two's complement.
- i_arg_B  in  WIDTH  operand B, two's complement.
- o_valid  out  1  result beat valid.
- i_ready  in  1  sink accepts a result beat.
- o_result  out  WIDTH  result.
- o_status  out  4  status flags.
- i_clr_cnt  in  1  synchronous clear of the overflow counter.
- o_ovf_count  out  CNT_W  saturating count of delivered overflow beats.

Behaviour:
- Reset (i_reset=0, async): all stage valids cleared. o_valid=0, o_result=0, o_status=0, o_ovf_count=0. o_ready=1 after reset release. In-flight beats are discarded.
- Input handshake: a beat is accepted on a rising edge with i_valid && o_ready. Output handshake: a beat completes on o_valid && i_ready.
- Pipeline: S1 registers the raw result plus an overflow bit; S2 registers o_result/o_status. Latency is 2: a beat accepted at edge N is valid at o_valid after edge N+1.
- Stall rules:
  - s2_adv = !o_valid || i_ready.
  - o_ready = !s1_valid || s2_adv (combinational).
  - Full throughput of 1 beat/cycle when unstalled.
  - While stalled, o_result/o_status are held stable.
  - No beat is lost or duplicated.
- SUB: compute A − 2·B sign-extended to WIDTH+2 bits. Overflow if the true result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]; otherwise result = low WIDTH bits.
- COMP: result = 1 if signed A < B, else 0. Equal operands give 0. Never overflows.
- SUM: compute A + B sign-extended to WIDTH+1 bits; overflow on signed out-of-range. Otherwise take sum, then clear bit index B when B (as unsigned) < WIDTH. If B ≥ WIDTH, sum is unchanged.
- CONV:
  - A ≥ 0: result = A.
  - A < 0: result = {1, magnitude(A)[WIDTH−2:0]}.
  - A = 100…0: overflow (magnitude not representable).
- Status when overflow: o_result = 0, o_status = 4'b1001. Never X.
- Status otherwise:
  - bit3 = bit0 = 0.
  - bit2 = 1 when the result has an even number of ones (zero counts as even).
  - bit1 = 1 when the result is all ones.
- Counter: increments by 1 on each completed output beat whose status is 1001. Saturates at 2^CNT_W−1. i_clr_cnt sets it to 0 next edge; clear wins over a simultaneous increment.
- Operands are sampled only on acceptance. Input changes while o_ready=0 have no effect.

Decomposition:
- Package alu_pkg holds:
  - op enum alu_op_e (ALU_SUB, ALU_COMP, ALU_SUM, ALU_CONV).
  - status constants STATUS_OVF=4'b1001, STATUS_EVEN_BIT=2, STATUS_ONES_BIT=1.
- One sub-module, sync_arith_core: purely combinational, WIDTH-parametrised. Takes op/A/B and produces raw result + overflow. Instantiated ahead of S1.
- Flag generation and all handshake/pipeline/counter logic live in the top module.

Test Plan (WIDTH=8):
- SUB A=0x0A, B=0x03 → o_result=0x04, o_status=0000, o_valid two edges after acceptance. SUB A=0x9C (−100), B=0x14 (20) → o_result=0x00, o_status=1001, o_ovf_count=1.
- SUM A=0x05, B=0x02 → 0x07 with bit2 cleared gives o_result=0x03, o_status=0100. SUM A=0x01, B=0x0A (B≥WIDTH) → o_result=0x0B, o_status=0000.
- CONV A=0xFB (−5) → o_result=0x85, o_status=0000. CONV A=0x80 → o_result=0x00, o_status=1001. CONV A=0xFF (−1) → 0x81, o_status=0100.
- COMP A=0xFE, B=0xFD → o_result=0x00, o_status=0100. A=0xFD, B=0xFE → o_result=0x01, o_status=0000. A=B=0x7F → 0x00.
- Backpressure: hold i_ready=0 and offer 4 beats back-to-back. Expect 2 accepted, then o_ready=0, with o_result held. Release i_ready → all beats emerge in order, none dropped or duplicated.
- Drive i_reset=0 mid-stream with 2 beats in flight → o_valid/o_result/o_status/o_ovf_count go to 0 immediately (async). After release, a new beat completes normally. Also: i_clr_cnt together with an overflow beat completing → counter=0.
